// File: rtl/paddle_color_tracker.sv
// Colour-blob tracker: turns the camera pixel stream into paddle geometry (centre, height, width).
// A bounding box of colour-matching pixels is built per frame and published at each vsync fall.
module paddle_color_tracker #(
  parameter int         ROWS       = 480,
  parameter int         COLS       = 640,
  parameter logic [7:0] R_MIN      = 8'd160,
  parameter logic [7:0] G_MAX      = 8'd80,
  parameter logic [7:0] B_MAX      = 8'd80,
  parameter int         MIN_PIXELS = 64,
  parameter int         DEF_ROW    = 240,
  parameter int         DEF_COL    = 320,
  parameter int         DEF_H      = 50,
  parameter int         DEF_W      = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        verticalSync,
  input  logic        active,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic [7:0]  i_R,
  input  logic [7:0]  i_G,
  input  logic [7:0]  i_B,
  output logic [12:0] cRow,
  output logic [12:0] cCol,
  output logic [12:0] cH,
  output logic [12:0] cW,
  output logic        found,
  output logic        frameDone
);

  typedef enum logic [1:0] {WAIT, ACCUM, PUBLISH} state_t;

  localparam logic [12:0] MIN_INIT = 13'h1FFF;
  localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

  state_t      state_q, state_d;
  logic [12:0] row_q, col_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        meta_q, sync_q0, sync_q1;
  logic [12:0] min_row_q, min_row_d, max_row_q, max_row_d;
  logic [12:0] min_col_q, min_col_d, max_col_q, max_col_d;
  logic [19:0] count_q, count_d;
  logic [12:0] snap_min_row_q, snap_min_row_d, snap_max_row_q, snap_max_row_d;
  logic [12:0] snap_min_col_q, snap_min_col_d, snap_max_col_q, snap_max_col_d;
  logic [19:0] snap_count_q, snap_count_d;
  logic [12:0] crow_q, crow_d, ccol_q, ccol_d, ch_q, ch_d, cw_q, cw_d;
  logic        found_q, found_d, frame_done_q, frame_done_d;

  logic        new_frame, in_frame, match;
  logic [13:0] row_sum, col_sum;

  // meta_q absorbs metastability; the edge is taken between the two following stages
  assign new_frame = sync_q1 & ~sync_q0;
  assign in_frame  = (row_q < 13'(ROWS)) && (col_q < 13'(COLS));
  assign match     = in_frame && (r_q >= R_MIN) && (g_q <= G_MAX) && (b_q <= B_MAX);
  assign row_sum   = {1'b0, snap_min_row_q} + {1'b0, snap_max_row_q};
  assign col_sum   = {1'b0, snap_min_col_q} + {1'b0, snap_max_col_q};

  always_comb begin
    state_d        = state_q;
    min_row_d      = min_row_q;
    max_row_d      = max_row_q;
    min_col_d      = min_col_q;
    max_col_d      = max_col_q;
    count_d        = count_q;
    snap_min_row_d = snap_min_row_q;
    snap_max_row_d = snap_max_row_q;
    snap_min_col_d = snap_min_col_q;
    snap_max_col_d = snap_max_col_q;
    snap_count_d   = snap_count_q;
    crow_d         = crow_q;
    ccol_d         = ccol_q;
    ch_d           = ch_q;
    cw_d           = cw_q;
    found_d        = found_q;
    frame_done_d   = 1'b0;

    // Snapshot and clear first, so a match on the boundary cycle lands in the new frame
    if (new_frame) begin
      snap_min_row_d = min_row_q;
      snap_max_row_d = max_row_q;
      snap_min_col_d = min_col_q;
      snap_max_col_d = max_col_q;
      snap_count_d   = count_q;
      min_row_d      = MIN_INIT;
      max_row_d      = '0;
      min_col_d      = MIN_INIT;
      max_col_d      = '0;
      count_d        = '0;
    end

    if (match) begin
      if (row_q < min_row_d) min_row_d = row_q;
      if (row_q > max_row_d) max_row_d = row_q;
      if (col_q < min_col_d) min_col_d = col_q;
      if (col_q > max_col_d) max_col_d = col_q;
      if (count_d != CNT_MAX) count_d = count_d + 20'd1;
    end

    case (state_q)
      WAIT:    if (new_frame) state_d = ACCUM;
      ACCUM:   if (new_frame) state_d = PUBLISH;
      PUBLISH: begin
        state_d      = ACCUM;
        frame_done_d = 1'b1;
        if (active) begin
          if (snap_count_q >= 20'(MIN_PIXELS)) begin
            crow_d  = row_sum[13:1];
            ccol_d  = col_sum[13:1];
            ch_d    = snap_max_row_q - snap_min_row_q + 13'd1;
            cw_d    = snap_max_col_q - snap_min_col_q + 13'd1;
            found_d = 1'b1;
          end else begin
            found_d = 1'b0;
          end
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= WAIT;
      row_q          <= '0;
      col_q          <= '0;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
      meta_q         <= 1'b1;
      sync_q0        <= 1'b1;
      sync_q1        <= 1'b1;
      min_row_q      <= MIN_INIT;
      max_row_q      <= '0;
      min_col_q      <= MIN_INIT;
      max_col_q      <= '0;
      count_q        <= '0;
      snap_min_row_q <= MIN_INIT;
      snap_max_row_q <= '0;
      snap_min_col_q <= MIN_INIT;
      snap_max_col_q <= '0;
      snap_count_q   <= '0;
      crow_q         <= 13'(DEF_ROW);
      ccol_q         <= 13'(DEF_COL);
      ch_q           <= 13'(DEF_H);
      cw_q           <= 13'(DEF_W);
      found_q        <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row;
      col_q          <= col;
      r_q            <= i_R;
      g_q            <= i_G;
      b_q            <= i_B;
      meta_q         <= verticalSync;
      sync_q0        <= meta_q;
      sync_q1        <= sync_q0;
      min_row_q      <= min_row_d;
      max_row_q      <= max_row_d;
      min_col_q      <= min_col_d;
      max_col_q      <= max_col_d;
      count_q        <= count_d;
      snap_min_row_q <= snap_min_row_d;
      snap_max_row_q <= snap_max_row_d;
      snap_min_col_q <= snap_min_col_d;
      snap_max_col_q <= snap_max_col_d;
      snap_count_q   <= snap_count_d;
      crow_q         <= crow_d;
      ccol_q         <= ccol_d;
      ch_q           <= ch_d;
      cw_q           <= cw_d;
      found_q        <= found_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign cRow      = crow_q;
  assign cCol      = ccol_q;
  assign cH        = ch_q;
  assign cW        = cw_q;
  assign found     = found_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_paddle_color_tracker.sv
// Directed bench for paddle_color_tracker: sparse pixel streams per frame, vsync falls,
// and hand-computed bounding-box results checked after each frameDone.
module tb_paddle_color_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        verticalSync;
  logic        active;
  logic [12:0] row, col;
  logic [7:0]  i_R, i_G, i_B;
  logic [12:0] cRow, cCol, cH, cW;
  logic        found, frameDone;

  int tests = 0;
  int fails = 0;

  paddle_color_tracker dut (
    .clk(clk), .reset_n(reset_n), .verticalSync(verticalSync), .active(active),
    .row(row), .col(col), .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .cRow(cRow), .cCol(cCol), .cH(cH), .cW(cW), .found(found), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  task automatic set_pix(input int r, input int c, input int rr, input int gg, input int bb);
    row = 13'(r); col = 13'(c); i_R = 8'(rr); i_G = 8'(gg); i_B = 8'(bb);
  endtask

  task automatic send_block(input int r0, input int r1, input int c0, input int c1,
                            input int rr, input int gg, input int bb);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) begin
        @(negedge clk);
        set_pix(r, c, rr, gg, bb);
      end
  endtask

  // Falling vsync; optionally places a red pixel at (10,10) on the cycle the tracker sees newFrame
  task automatic vsync_fall(input bit inject);
    @(negedge clk); verticalSync = 1'b0; set_pix(0, 0, 0, 0, 0);
    @(negedge clk); if (inject) set_pix(10, 10, 255, 0, 0); else set_pix(0, 0, 0, 0, 0);
    @(negedge clk); verticalSync = 1'b1; set_pix(0, 0, 0, 0, 0);
  endtask

  task automatic wait_frame_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(posedge clk); #1;
      if (frameDone === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit seen;
    reset_n = 1'b0; verticalSync = 1'b1; active = 1'b1; set_pix(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({cRow, cCol, cH, cW, found} !== {13'd240, 13'd320, 13'd50, 13'd20, 1'b0}) begin
      fails++;
      $display("FAIL reset_geom: got row=%0d col=%0d h=%0d w=%0d found=%0d, want 240 320 50 20 0", cRow, cCol, cH, cW, found);
    end
    tests++;
    if (frameDone !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %0b want 0", frameDone);
    end
    @(negedge clk); reset_n = 1'b1;
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL reset_first_vsync: frameDone seen=%0b want 0", seen);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic;
    bit seen;
    send_block(100, 149, 200, 219, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (seen !== 1'b1) begin
      fails++; $display("FAIL basic_done: frameDone seen=%0b want 1", seen);
    end
    tests++;
    if ({cRow, cCol, cH, cW, found} !== {13'd124, 13'd209, 13'd50, 13'd20, 1'b1}) begin
      fails++;
      $display("FAIL basic_geom: got row=%0d col=%0d h=%0d w=%0d found=%0d, want 124 209 50 20 1", cRow, cCol, cH, cW, found);
    end
    @(posedge clk); #1;
    tests++;
    if (frameDone !== 1'b0) begin
      fails++; $display("FAIL basic_pulse_width: frameDone=%0b want 0", frameDone);
    end
    $display("[TB] test_basic done");
  endtask

  task automatic test_inactive;
    bit seen;
    active = 1'b0;
    send_block(0, 7, 0, 7, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (seen !== 1'b1) begin
      fails++; $display("FAIL inactive_done: frameDone seen=%0b want 1", seen);
    end
    tests++;
    if ({cRow, cCol, cH, cW, found} !== {13'd124, 13'd209, 13'd50, 13'd20, 1'b1}) begin
      fails++;
      $display("FAIL inactive_hold: got row=%0d col=%0d h=%0d w=%0d found=%0d, want 124 209 50 20 1", cRow, cCol, cH, cW, found);
    end
    active = 1'b1;
    $display("[TB] test_inactive done");
  endtask

  task automatic test_min_pixels;
    bit seen;
    send_block(300, 300, 0, 62, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (!seen || {cRow, cCol, cH, cW, found} !== {13'd124, 13'd209, 13'd50, 13'd20, 1'b0}) begin
      fails++;
      $display("FAIL min63: seen=%0b row=%0d col=%0d h=%0d w=%0d found=%0d, want 1 124 209 50 20 0", seen, cRow, cCol, cH, cW, found);
    end
    send_block(300, 300, 0, 63, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (!seen || {cRow, cCol, cH, cW, found} !== {13'd300, 13'd31, 13'd1, 13'd64, 1'b1}) begin
      fails++;
      $display("FAIL min64: seen=%0b row=%0d col=%0d h=%0d w=%0d found=%0d, want 1 300 31 1 64 1", seen, cRow, cCol, cH, cW, found);
    end
    $display("[TB] test_min_pixels done");
  endtask

  task automatic test_reject;
    bit seen;
    send_block(480, 480, 0, 99, 255, 0, 0);
    send_block(0, 99, 640, 640, 255, 0, 0);
    send_block(10, 10, 0, 99, 255, 81, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (seen !== 1'b1) begin
      fails++; $display("FAIL reject_done: frameDone seen=%0b want 1", seen);
    end
    tests++;
    if ({cRow, cCol, cH, cW, found} !== {13'd300, 13'd31, 13'd1, 13'd64, 1'b0}) begin
      fails++;
      $display("FAIL reject_geom: got row=%0d col=%0d h=%0d w=%0d found=%0d, want 300 31 1 64 0", cRow, cCol, cH, cW, found);
    end
    $display("[TB] test_reject done");
  endtask

  task automatic test_boundary_pixel;
    bit seen;
    vsync_fall(1'b1);
    wait_frame_done(seen);
    tests++;
    if (!seen || found !== 1'b0) begin
      fails++; $display("FAIL edge_empty_frame: seen=%0b found=%0b want 1 0", seen, found);
    end
    send_block(100, 149, 200, 219, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (!seen || {cRow, cCol, cH, cW, found} !== {13'd79, 13'd114, 13'd140, 13'd210, 1'b1}) begin
      fails++;
      $display("FAIL edge_pixel_box: seen=%0b row=%0d col=%0d h=%0d w=%0d found=%0d, want 1 79 114 140 210 1", seen, cRow, cCol, cH, cW, found);
    end
    $display("[TB] test_boundary_pixel done");
  endtask

  task automatic test_reset_midframe;
    bit seen;
    send_block(0, 4, 0, 19, 255, 0, 0);
    @(negedge clk); reset_n = 1'b0;
    #1;
    tests++;
    if ({cRow, cCol, cH, cW, found, frameDone} !== {13'd240, 13'd320, 13'd50, 13'd20, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midreset_geom: got row=%0d col=%0d h=%0d w=%0d found=%0d done=%0b, want 240 320 50 20 0 0", cRow, cCol, cH, cW, found, frameDone);
    end
    @(negedge clk); reset_n = 1'b1;
    send_block(100, 149, 200, 219, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL midreset_wait: frameDone seen=%0b want 0", seen);
    end
    send_block(100, 149, 200, 219, 255, 0, 0);
    vsync_fall(1'b0);
    wait_frame_done(seen);
    tests++;
    if (!seen || {cRow, cCol, cH, cW, found} !== {13'd124, 13'd209, 13'd50, 13'd20, 1'b1}) begin
      fails++;
      $display("FAIL midreset_recover: seen=%0b row=%0d col=%0d h=%0d w=%0d found=%0d, want 1 124 209 50 20 1", seen, cRow, cCol, cH, cW, found);
    end
    $display("[TB] test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inactive();
    test_min_pixels();
    test_reject();
    test_boundary_pixel();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
